// File: rtl/bsg_manycore_reset_sequencer.sv
// Multi-channel reset sequencer: holds channels in reset, releases them one after another,
// waits for each channel's tag-done with a timeout, then settles before signalling ready.
module bsg_manycore_reset_sequencer #(
  parameter int unsigned num_channels_p      = 4,
  parameter int unsigned reset_hold_cycles_p = 16,
  parameter int unsigned stagger_cycles_p    = 4,
  parameter int unsigned done_delay_p        = 3,
  parameter int unsigned timeout_cycles_p    = 1024,
  parameter int unsigned ctr_width_p         = 64
) (
  input  logic                      clk_i,
  input  logic                      reset_n_i,
  input  logic                      start_i,
  input  logic [num_channels_p-1:0] chan_en_i,
  input  logic [num_channels_p-1:0] tag_done_i,
  output logic [num_channels_p-1:0] chan_reset_o,
  output logic [num_channels_p-1:0] chan_done_o,
  output logic                      busy_o,
  output logic                      all_done_o,
  output logic                      timeout_o,
  output logic [num_channels_p-1:0] timeout_chan_o,
  output logic [ctr_width_p-1:0]    cycle_ctr_o,
  output logic [ctr_width_p-1:0]    done_cycle_o
);

  // One shared phase counter serves hold, stagger, timeout and settle timing.
  localparam int unsigned max_rs_lp = (reset_hold_cycles_p > stagger_cycles_p) ?
                                      reset_hold_cycles_p : stagger_cycles_p;
  localparam int unsigned max_dt_lp = (done_delay_p > timeout_cycles_p) ?
                                      done_delay_p : timeout_cycles_p;
  localparam int unsigned max_lp    = (max_rs_lp > max_dt_lp) ? max_rs_lp : max_dt_lp;
  localparam int unsigned cnt_w_lp  = $clog2(max_lp + 1);

  localparam logic [cnt_w_lp-1:0] hold_last_lp    = cnt_w_lp'(reset_hold_cycles_p - 1);
  localparam logic [cnt_w_lp-1:0] stagger_last_lp = cnt_w_lp'(stagger_cycles_p - 1);
  localparam logic [cnt_w_lp-1:0] timeout_last_lp = cnt_w_lp'(timeout_cycles_p - 1);
  localparam logic [cnt_w_lp-1:0] delay_last_lp   = cnt_w_lp'(done_delay_p - 1);

  typedef enum logic [2:0] {StHold, StRelease, StWait, StDelay, StDone, StError} state_e;

  state_e                    state_q, state_d;
  logic [cnt_w_lp-1:0]       cnt_q, cnt_d;
  logic [num_channels_p-1:0] mask_q, mask_d;
  logic [num_channels_p-1:0] pend_q, pend_d;
  logic [num_channels_p-1:0] rel_q, rel_d;
  logic [num_channels_p-1:0] done_q, done_d;
  logic [num_channels_p-1:0] tchan_q, tchan_d;
  logic [ctr_width_p-1:0]    ctr_q, ctr_d;
  logic [ctr_width_p-1:0]    done_cycle_q, done_cycle_d;

  logic [num_channels_p-1:0] low, rel_now, released, done_all, mask_cur, pend_rest;
  logic                      found, all_ok;

  always_comb begin
    low   = '0;
    found = 1'b0;
    for (int i = 0; i < int'(num_channels_p); i++) begin
      if (pend_q[i] && !found) begin
        low[i] = 1'b1;
        found  = 1'b1;
      end
    end

    // The channel being released this cycle drops its reset without waiting for a register.
    rel_now   = (state_q == StRelease && cnt_q == '0) ? low : '0;
    released  = rel_q | rel_now;
    done_all  = done_q | (tag_done_i & mask_q & released);
    all_ok    = ((done_all & mask_q) == mask_q);
    mask_cur  = (cnt_q == '0) ? chan_en_i : mask_q;
    pend_rest = pend_q & ~low;

    state_d      = state_q;
    cnt_d        = cnt_q + cnt_w_lp'(1);
    mask_d       = mask_q;
    pend_d       = pend_q;
    rel_d        = rel_q;
    tchan_d      = tchan_q;
    ctr_d        = ctr_q + ctr_width_p'(1);
    done_cycle_d = done_cycle_q;

    unique case (state_q)
      StHold: begin
        if (cnt_q == '0) mask_d = chan_en_i;
        if (cnt_q == hold_last_lp) begin
          pend_d  = mask_cur;
          cnt_d   = '0;
          state_d = (mask_cur == '0) ? StWait : StRelease;
        end
      end
      StRelease: begin
        if (cnt_q == '0) begin
          pend_d = pend_rest;
          rel_d  = rel_q | low;
        end
        if (cnt_q == '0 && pend_rest == '0) begin
          cnt_d   = '0;
          state_d = StWait;
        end else if (cnt_q == stagger_last_lp) begin
          cnt_d = '0;
        end
      end
      StWait: begin
        if (all_ok) begin
          cnt_d   = '0;
          state_d = (done_delay_p == 0) ? StDone : StDelay;
        end else if (cnt_q == timeout_last_lp) begin
          cnt_d   = '0;
          tchan_d = mask_q & ~done_all;
          state_d = StError;
        end
      end
      StDelay: begin
        if (cnt_q == delay_last_lp) begin
          cnt_d   = '0;
          state_d = StDone;
        end
      end
      StDone, StError: begin
        cnt_d = cnt_q;
        if (start_i) begin
          cnt_d   = '0;
          state_d = StHold;
        end
      end
      default: state_d = StHold;
    endcase

    if (state_d == StHold) begin
      pend_d  = '0;
      rel_d   = '0;
      tchan_d = '0;
    end
    done_d = (state_d == StHold) ? '0 : done_all;

    if (state_d == StDone && state_q != StDone) done_cycle_d = ctr_d;
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q      <= StHold;
      cnt_q        <= '0;
      mask_q       <= '0;
      pend_q       <= '0;
      rel_q        <= '0;
      done_q       <= '0;
      tchan_q      <= '0;
      ctr_q        <= '0;
      done_cycle_q <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      mask_q       <= mask_d;
      pend_q       <= pend_d;
      rel_q        <= rel_d;
      done_q       <= done_d;
      tchan_q      <= tchan_d;
      ctr_q        <= ctr_d;
      done_cycle_q <= done_cycle_d;
    end
  end

  assign chan_reset_o   = ~released;
  assign chan_done_o    = done_q;
  assign busy_o         = (state_q == StHold) || (state_q == StRelease) ||
                          (state_q == StWait) || (state_q == StDelay);
  assign all_done_o     = (state_q == StDone);
  assign timeout_o      = (state_q == StError);
  assign timeout_chan_o = tchan_q;
  assign cycle_ctr_o    = ctr_q;
  assign done_cycle_o   = done_cycle_q;

endmodule

// File: tb/tb_bsg_manycore_reset_sequencer.sv
// Directed bench: three sequencer instances (defaults, short timeout, zero settle delay)
// share one stimulus stream; each scenario checks the instance it targets.
module tb_bsg_manycore_reset_sequencer;

  localparam int unsigned N = 4;
  localparam int unsigned W = 64;

  logic         clk = 1'b0;
  logic         reset_n;
  logic         start;
  logic [N-1:0] chan_en;
  logic [N-1:0] tag_done;

  logic [N-1:0] d_chan_reset, d_chan_done, d_tchan;
  logic         d_busy, d_all_done, d_timeout;
  logic [W-1:0] d_ctr, d_done_cycle;
  logic [N-1:0] t_chan_reset, t_chan_done, t_tchan;
  logic         t_busy, t_all_done, t_timeout;
  logic [W-1:0] t_ctr, t_done_cycle;
  logic [N-1:0] z_chan_reset, z_chan_done, z_tchan;
  logic         z_busy, z_all_done, z_timeout;
  logic [W-1:0] z_ctr, z_done_cycle;

  bsg_manycore_reset_sequencer u_def (
    .clk_i(clk), .reset_n_i(reset_n), .start_i(start), .chan_en_i(chan_en),
    .tag_done_i(tag_done), .chan_reset_o(d_chan_reset), .chan_done_o(d_chan_done),
    .busy_o(d_busy), .all_done_o(d_all_done), .timeout_o(d_timeout),
    .timeout_chan_o(d_tchan), .cycle_ctr_o(d_ctr), .done_cycle_o(d_done_cycle)
  );

  bsg_manycore_reset_sequencer #(.timeout_cycles_p(8)) u_tmo (
    .clk_i(clk), .reset_n_i(reset_n), .start_i(start), .chan_en_i(chan_en),
    .tag_done_i(tag_done), .chan_reset_o(t_chan_reset), .chan_done_o(t_chan_done),
    .busy_o(t_busy), .all_done_o(t_all_done), .timeout_o(t_timeout),
    .timeout_chan_o(t_tchan), .cycle_ctr_o(t_ctr), .done_cycle_o(t_done_cycle)
  );

  bsg_manycore_reset_sequencer #(.done_delay_p(0)) u_nod (
    .clk_i(clk), .reset_n_i(reset_n), .start_i(start), .chan_en_i(chan_en),
    .tag_done_i(tag_done), .chan_reset_o(z_chan_reset), .chan_done_o(z_chan_done),
    .busy_o(z_busy), .all_done_o(z_all_done), .timeout_o(z_timeout),
    .timeout_chan_o(z_tchan), .cycle_ctr_o(z_ctr), .done_cycle_o(z_done_cycle)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int k = 0;
  int tag_at [N];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // k counts rising edges since reset release; tag_done[i] rises right after edge tag_at[i].
  task automatic tick();
    @(posedge clk);
    #1;
    k++;
    for (int i = 0; i < int'(N); i++) if (tag_at[i] == k) tag_done[i] = 1'b1;
  endtask

  task automatic go_to(input int n);
    while (k < n) tick();
  endtask

  task automatic restart(input logic [N-1:0] mask);
    reset_n  = 1'b0;
    start    = 1'b0;
    tag_done = '0;
    chan_en  = mask;
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    k       = 0;
  endtask

  task automatic set_tags(input int a, input int b, input int c, input int d);
    tag_at[0] = a; tag_at[1] = b; tag_at[2] = c; tag_at[3] = d;
  endtask

  initial begin
    reset_n  = 1'b0;
    start    = 1'b0;
    chan_en  = 4'hF;
    tag_done = '0;
    set_tags(0, 0, 0, 0);
    #3;
    check("rst_chan_reset", 64'(d_chan_reset), 64'hF);
    check("rst_chan_done", 64'(d_chan_done), 64'h0);
    check("rst_busy", 64'(d_busy), 64'h1);
    check("rst_all_done", 64'(d_all_done), 64'h0);
    check("rst_timeout", 64'(d_timeout), 64'h0);
    check("rst_tchan", 64'(d_tchan), 64'h0);
    check("rst_ctr", d_ctr, 64'h0);
    check("rst_done_cycle", d_done_cycle, 64'h0);

    // Full mask, each tag two cycles after its own release.
    set_tags(18, 22, 26, 30);
    restart(4'hF);
    go_to(15); check("t1_hold_end", 64'(d_chan_reset), 64'hF);
    go_to(16); check("t1_rel0", 64'(d_chan_reset), 64'hE);
    go_to(19); check("t1_pre_rel1", 64'(d_chan_reset), 64'hE);
    go_to(20); check("t1_rel1", 64'(d_chan_reset), 64'hC);
    go_to(24); check("t1_rel2", 64'(d_chan_reset), 64'h8);
    go_to(28); check("t1_rel3", 64'(d_chan_reset), 64'h0);
    go_to(30); check("t1_done_partial", 64'(d_chan_done), 64'h7);
    go_to(31); check("t1_done_all", 64'(d_chan_done), 64'hF);
    go_to(33); check("t1_settling", 64'(d_all_done), 64'h0);
    go_to(34); check("t1_all_done", 64'(d_all_done), 64'h1);
    check("t1_busy", 64'(d_busy), 64'h0);
    check("t1_ctr", d_ctr, 64'd34);
    check("t1_done_cycle", d_done_cycle, 64'd34);

    // Sparse mask: channels 0 and 2 never released, tag_done[0] ignored.
    set_tags(0, 17, 0, 21);
    restart(4'hA);
    tag_done[0] = 1'b1;
    go_to(15); check("t2_hold_end", 64'(d_chan_reset), 64'hF);
    go_to(16); check("t2_rel1", 64'(d_chan_reset), 64'hD);
    go_to(19); check("t2_gap", 64'(d_chan_reset), 64'hD);
    go_to(20); check("t2_rel3", 64'(d_chan_reset), 64'h5);
    go_to(22); check("t2_chan_done", 64'(d_chan_done), 64'hA);
    check("t2_not_yet", 64'(d_all_done), 64'h0);
    go_to(25); check("t2_all_done", 64'(d_all_done), 64'h1);
    check("t2_chan_reset", 64'(d_chan_reset), 64'h5);

    // Short timeout, channel 2 never reports done.
    set_tags(18, 22, 0, 30);
    restart(4'hF);
    go_to(36); check("t3_pre_timeout", 64'(t_timeout), 64'h0);
    check("t3_pre_busy", 64'(t_busy), 64'h1);
    go_to(37); check("t3_timeout", 64'(t_timeout), 64'h1);
    check("t3_tchan", 64'(t_tchan), 64'h4);
    check("t3_all_done", 64'(t_all_done), 64'h0);
    check("t3_released", 64'(t_chan_reset), 64'h0);
    check("t3_busy", 64'(t_busy), 64'h0);
    go_to(38);
    start = 1'b1;
    tick();
    start = 1'b0;
    check("t3_restart_reset", 64'(t_chan_reset), 64'hF);
    check("t3_restart_timeout", 64'(t_timeout), 64'h0);
    check("t3_restart_tchan", 64'(t_tchan), 64'h0);
    check("t3_restart_done", 64'(t_chan_done), 64'h0);
    check("t3_restart_busy", 64'(t_busy), 64'h1);

    // Last tag arrives in the final timeout cycle: completion wins.
    set_tags(18, 22, 26, 36);
    restart(4'hF);
    go_to(37); check("t4_no_timeout", 64'(t_timeout), 64'h0);
    check("t4_busy", 64'(t_busy), 64'h1);
    check("t4_chan_done", 64'(t_chan_done), 64'hF);
    go_to(39); check("t4_settling", 64'(t_all_done), 64'h0);
    go_to(40); check("t4_all_done", 64'(t_all_done), 64'h1);
    check("t4_timeout_low", 64'(t_timeout), 64'h0);

    // Empty mask with zero settle delay.
    set_tags(0, 0, 0, 0);
    restart(4'h0);
    go_to(16); check("t5_wait", 64'(z_all_done), 64'h0);
    check("t5_busy", 64'(z_busy), 64'h1);
    go_to(17); check("t5_all_done", 64'(z_all_done), 64'h1);
    check("t5_chan_reset", 64'(z_chan_reset), 64'hF);

    // Async reset mid-release, rerun, start ignored while waiting.
    set_tags(18, 22, 26, 30);
    restart(4'hF);
    go_to(21); check("t6_mid_release", 64'(d_chan_reset), 64'hC);
    reset_n = 1'b0;
    #1;
    check("t6_async_reset", 64'(d_chan_reset), 64'hF);
    check("t6_async_ctr", d_ctr, 64'h0);
    check("t6_async_done", 64'(d_chan_done), 64'h0);
    check("t6_async_busy", 64'(d_busy), 64'h1);
    restart(4'hF);
    go_to(29);
    start = 1'b1;
    tick();
    start = 1'b0;
    check("t6_start_ignored", 64'(d_busy), 64'h1);
    go_to(31); check("t6_still_busy", 64'(d_busy), 64'h1);
    go_to(34); check("t6_all_done", 64'(d_all_done), 64'h1);
    check("t6_done_cycle", d_done_cycle, 64'd34);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/bsg_manycore_reset_sequencer.md
Name: bsg_manycore_reset_sequencer

Overview:
Parametrised multi-channel reset and tag-done sequencer for the manycore testbench and host complex. It holds a configurable number of downstream channels (pods or host endpoints) in reset, then releases them in a staggered order. It waits for each channel's tag-programming-done indication, with a timeout, and applies a programmable settle delay before declaring the system ready. It also provides a free-running global cycle counter and timestamps the cycle at which the sequence completes.

Parameters:
num_channels_p, 4, number of downstream reset channels (>=1)
reset_hold_cycles_p, 16, cycles all enabled channels are held in reset before the first release (>=1)
stagger_cycles_p, 4, cycles between consecutive channel releases (>=1)
done_delay_p, 3, settle cycles between "all tags done" and all_done_o (>=0)
timeout_cycles_p, 1024, maximum cycles spent waiting for tag_done before error (>=1)
ctr_width_p, 64, width of the global cycle counter

Ports:
clk_i  in  1  single clock
reset_n_i  in  1  asynchronous, active-low reset
start_i  in  1  restart request; honoured only in DONE or ERROR
chan_en_i  in  num_channels_p  channel enable mask; latched on HOLD entry
tag_done_i  in  num_channels_p  per-channel tag-programming-done level
chan_reset_o  out  num_channels_p  active-high reset to each channel
chan_done_o  out  num_channels_p  sticky per-channel done
busy_o  out  1  high in HOLD, RELEASE, WAIT and DELAY
all_done_o  out  1  high only in DONE
timeout_o  out  1  high only in ERROR
timeout_chan_o  out  num_channels_p  enabled channels not done when the timeout fired
cycle_ctr_o  out  ctr_width_p  free-running cycle count
done_cycle_o  out  ctr_width_p  cycle_ctr_o value captured on DONE entry

Behaviour:
- Reset (reset_n_i=0, async):
  - chan_reset_o all 1; chan_done_o, timeout_chan_o, cycle_ctr_o, done_cycle_o all 0; busy_o=1; all_done_o=0; timeout_o=0.
  - State is HOLD; the enable mask is latched from chan_en_i on the first rising edge after deassertion.
- cycle_ctr_o: increments every cycle after reset is released and wraps modulo 2^ctr_width_p. It is never cleared by start_i.
- States: HOLD, RELEASE, WAIT, DELAY, DONE, ERROR.
- HOLD:
  - Lasts exactly reset_hold_cycles_p cycles.
  - All chan_reset_o=1; chan_done_o and timeout_chan_o cleared on entry.
  - Then goes to RELEASE.
- RELEASE:
  - Walks channel indices 0 to N-1.
  - The lowest enabled channel's chan_reset_o drops in the first RELEASE cycle.
  - Each subsequent enabled channel drops stagger_cycles_p cycles after the previous release.
  - Disabled channels are skipped and consume no cycles; their chan_reset_o stays 1 for the whole sequence.
  - The cycle after the last enabled release (or the cycle after HOLD if the mask is all zero), the FSM enters WAIT.
- chan_done_o[i]:
  - Sets on the first cycle that tag_done_i[i]=1 while channel i is enabled and released.
  - Sticky until the next HOLD.
  - tag_done_i on an unreleased or disabled channel is ignored.
- WAIT:
  - The timeout counter clears on entry and increments each cycle.
  - When all enabled channels have chan_done_o=1 (counting bits setting in the same cycle), the FSM goes to DELAY. An empty mask completes on the first WAIT cycle.
  - If the counter reaches timeout_cycles_p without completion, the FSM goes to ERROR and timeout_chan_o = mask & ~chan_done_o.
  - If completion and timeout occur in the same cycle, completion wins.
- DELAY:
  - Lasts done_delay_p cycles, then goes to DONE.
  - With done_delay_p=0 the FSM goes WAIT to DONE directly.
- DONE:
  - all_done_o=1; done_cycle_o is captured on entry.
  - A later tag_done_i deassertion has no effect.
- ERROR:
  - timeout_o=1; released channels stay released.
- start_i:
  - In DONE or ERROR, the next state is HOLD: all chan_reset_o reassert the next cycle, all_done_o and timeout_o clear, and the mask is re-latched.
  - start_i is ignored in all other states.
- Asynchronous reset mid-sequence returns every output to its reset value immediately.

Test Plan:
- Defaults, mask 4'b1111, each tag_done_i raised 2 cycles after its own release:
  - chan_reset_o bits drop at HOLD+0/+4/+8/+12 cycles.
  - all_done_o rises done_delay_p=3 cycles after chan_done_o[3] sets.
  - done_cycle_o equals cycle_ctr_o at that edge.
- Mask 4'b1010:
  - Channel 1 is released on the first RELEASE cycle and channel 3 four cycles later.
  - chan_reset_o[0] and chan_reset_o[2] stay 1 throughout.
  - tag_done_i[0]=1 is ignored and chan_done_o[0]=0.
- timeout_cycles_p=8, tag_done_i[2] never asserted:
  - timeout_o=1 exactly 8 cycles after WAIT entry.
  - timeout_chan_o=4'b0100 and all_done_o=0.
  - A start_i pulse then returns the FSM to HOLD with outputs cleared.
- Last tag_done arrives on the same cycle the timeout counter hits its limit -> DELAY then DONE; timeout_o stays 0.
- Mask 4'b0000 with done_delay_p=0 -> all_done_o=1 two cycles after HOLD ends, with all chan_reset_o still 1.
- Assert reset_n_i=0 during RELEASE:
  - All chan_reset_o return to 1 combinationally and cycle_ctr_o=0.
  - After release, the full sequence reruns.
  - start_i pulses during WAIT are ignored.
